// File: rtl/matrix_slot_allocator.sv
// Slot allocator for the shared matrix memory: keeps per-(m,n) occupancy bounded
// and replaces the oldest matrix (by allocation order) when a slot must be reused.
module matrix_slot_allocator #(
  parameter int NUM_SLOTS   = 8,
  parameter int SLOT_WORDS  = 27,
  parameter int MAX_PER_DIM = 2,
  parameter int BASE_OFFSET = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  input  logic [31:0]                  req_m,
  input  logic [31:0]                  req_n,
  input  logic                         clear_all,
  output logic [7:0]                   base_addr,
  output logic                         addr_ready,
  output logic [$clog2(NUM_SLOTS)-1:0] alloc_slot,
  output logic                         evicted,
  output logic                         alloc_err,
  output logic                         busy,
  output logic [4:0]                   slot_count
);

  localparam int SW = $clog2(NUM_SLOTS);

  typedef enum logic [2:0] {IDLE, SCAN, DECIDE, GRANT, WAIT_DROP} state_t;

  state_t              state;
  logic [SW-1:0]       idx;
  logic [2:0]          lat_m, lat_n;

  logic [NUM_SLOTS-1:0] slot_valid;
  logic [2:0]           slot_m    [NUM_SLOTS];
  logic [2:0]           slot_n    [NUM_SLOTS];
  logic [SW-1:0]        slot_rank [NUM_SLOTS];

  // Scan accumulators
  logic [4:0]    same_cnt;
  logic          free_found, same_found, any_found;
  logic [SW-1:0] first_free, oldest_same, oldest_any;
  logic [SW-1:0] same_rank, any_rank;

  logic          cur_valid, cur_same;
  logic [SW-1:0] cur_rank;
  logic [SW-1:0] target, target_rank;
  logic          target_evict;
  logic [4:0]    valid_cnt;
  logic          dims_legal;
  int            addr_calc;

  assign cur_valid  = slot_valid[idx];
  assign cur_same   = cur_valid && (slot_m[idx] == lat_m) && (slot_n[idx] == lat_n);
  assign cur_rank   = slot_rank[idx];
  assign dims_legal = (req_m != 32'd0) && (req_m <= 32'd5) &&
                      (req_n != 32'd0) && (req_n <= 32'd5);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    target       = oldest_any;
    target_evict = 1'b1;
    if (int'(same_cnt) >= MAX_PER_DIM) begin
      target = oldest_same;
    end else if (free_found) begin
      target       = first_free;
      target_evict = 1'b0;
    end
    target_rank = slot_rank[target];
    addr_calc   = BASE_OFFSET + SLOT_WORDS * int'(target);
  end

  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) valid_cnt = valid_cnt + 5'(slot_valid[i]);
  end

  // NOTE: state is updated with non-blocking assignments so every read in this
  // block sees the pre-edge value, independent of statement order.
  // NOTE: the slot table is a handful of flops, not a RAM, so it is reset directly;
  // "all slots invalid" must hold immediately after rst_n asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      lat_m       <= '0;
      lat_n       <= '0;
      same_cnt    <= '0;
      free_found  <= 1'b0;
      same_found  <= 1'b0;
      any_found   <= 1'b0;
      first_free  <= '0;
      oldest_same <= '0;
      oldest_any  <= '0;
      same_rank   <= '0;
      any_rank    <= '0;
      slot_valid  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_m[i]    <= '0;
        slot_n[i]    <= '0;
        slot_rank[i] <= '0;
      end
      base_addr  <= '0;
      alloc_slot <= '0;
      addr_ready <= 1'b0;
      evicted    <= 1'b0;
      alloc_err  <= 1'b0;
      busy       <= 1'b0;
      slot_count <= '0;
    end else begin
      slot_count <= valid_cnt;
      addr_ready <= 1'b0;
      evicted    <= 1'b0;
      alloc_err  <= 1'b0;
      if (clear_all) begin
        slot_valid <= '0;
        for (int i = 0; i < NUM_SLOTS; i++) slot_rank[i] <= '0;
        busy  <= 1'b0;
        state <= WAIT_DROP;
      end else begin
        case (state)
          IDLE: if (req_valid) begin
            lat_m <= req_m[2:0];
            lat_n <= req_n[2:0];
            if (dims_legal) begin
              idx        <= '0;
              same_cnt   <= '0;
              free_found <= 1'b0;
              same_found <= 1'b0;
              any_found  <= 1'b0;
              busy       <= 1'b1;
              state      <= SCAN;
            end else begin
              alloc_err <= 1'b1;
              state     <= WAIT_DROP;
            end
          end
          SCAN: begin
            if (cur_valid) begin
              if (!any_found || cur_rank > any_rank) begin
                any_found  <= 1'b1;
                oldest_any <= idx;
                any_rank   <= cur_rank;
              end
              if (cur_same) begin
                same_cnt <= same_cnt + 5'd1;
                if (!same_found || cur_rank > same_rank) begin
                  same_found  <= 1'b1;
                  oldest_same <= idx;
                  same_rank   <= cur_rank;
                end
              end
            end else if (!free_found) begin
              free_found <= 1'b1;
              first_free <= idx;
            end
            idx <= idx + 1'b1;
            if (idx == SW'(NUM_SLOTS - 1)) state <= DECIDE;
          end
          DECIDE: begin
            // Age everything younger than the reused slot (or everything, if it was free).
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (slot_valid[i] && (!target_evict || slot_rank[i] < target_rank))
                slot_rank[i] <= slot_rank[i] + 1'b1;
            end
            slot_valid[target] <= 1'b1;
            slot_m[target]     <= lat_m;
            slot_n[target]     <= lat_n;
            slot_rank[target]  <= '0;
            base_addr  <= addr_calc[7:0];
            alloc_slot <= target;
            evicted    <= target_evict;
            addr_ready <= 1'b1;
            state      <= GRANT;
          end
          GRANT: begin
            busy  <= 1'b0;
            state <= WAIT_DROP;
          end
          WAIT_DROP: if (!req_valid) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_slot_allocator.sv
// Directed bench for matrix_slot_allocator: stimulus queues expected grants/errors,
// a monitor compares them whenever addr_ready or alloc_err is presented.
module tb_matrix_slot_allocator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_m = '0;
  logic [31:0] req_n = '0;
  logic        clear_all = 1'b0;
  logic [7:0]  base_addr;
  logic        addr_ready;
  logic [2:0]  alloc_slot;
  logic        evicted;
  logic        alloc_err;
  logic        busy;
  logic [4:0]  slot_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    bit is_err;
    int slot;
    int base;
    bit ev;
    int at_cyc;
  } exp_t;

  exp_t sb[$];

  matrix_slot_allocator dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_m(req_m), .req_n(req_n),
    .clear_all(clear_all), .base_addr(base_addr), .addr_ready(addr_ready),
    .alloc_slot(alloc_slot), .evicted(evicted), .alloc_err(alloc_err), .busy(busy),
    .slot_count(slot_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per presented grant or error pulse.
  always @(negedge clk) begin
    if (rst_n && (addr_ready || alloc_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_cycle", cyc, e.at_cyc);
        check("alloc_err", int'(alloc_err), int'(e.is_err));
        check("addr_ready", int'(addr_ready), int'(!e.is_err));
        if (!e.is_err) begin
          check("alloc_slot", int'(alloc_slot), e.slot);
          check("base_addr", int'(base_addr), e.base);
          check("evicted", int'(evicted), int'(e.ev));
        end
      end
    end
  end

  task automatic request(input logic [31:0] m, input logic [31:0] n, input bit err,
                         input int slot, input bit ev, input int hold, input int gap);
    exp_t e;
    int   k;
    @(negedge clk);
    req_valid = 1'b1;
    req_m = m;
    req_n = n;
    e.is_err = err;
    e.slot   = slot;
    e.base   = slot * 27;
    e.ev     = ev;
    e.at_cyc = err ? cyc + 1 : cyc + 10;
    sb.push_back(e);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(addr_ready || alloc_err) && k < 40);
    if (k >= 40) check("response_timeout", 0, 1);
    repeat (hold) @(negedge clk);
    req_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Raise a request and cut it short after `after` negedges with clear_all or rst_n.
  task automatic abort_request(input logic [31:0] m, input logic [31:0] n,
                               input int after, input bit use_reset);
    @(negedge clk);
    req_valid = 1'b1;
    req_m = m;
    req_n = n;
    repeat (after) @(negedge clk);
    check("busy_before_abort", int'(busy), 1);
    if (use_reset) begin
      rst_n = 1'b0;
      #1;
      check("rst_addr_ready", int'(addr_ready), 0);
      check("rst_slot_count", int'(slot_count), 0);
      check("rst_busy", int'(busy), 0);
    end else begin
      clear_all = 1'b1;
    end
    @(negedge clk);
    clear_all = 1'b0;
    rst_n = 1'b1;
    req_valid = 1'b0;
    check("busy_after_abort", int'(busy), 0);
    repeat (14) @(negedge clk);
    check("abort_slot_count", int'(slot_count), 0);
  endtask

  initial begin
    #12;
    check("reset_base_addr", int'(base_addr), 0);
    check("reset_alloc_slot", int'(alloc_slot), 0);
    check("reset_slot_count", int'(slot_count), 0);
    check("reset_addr_ready", int'(addr_ready), 0);
    check("reset_evicted", int'(evicted), 0);
    check("reset_alloc_err", int'(alloc_err), 0);
    check("reset_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Same-dimension cap: third 2x3 replaces the older 2x3 in slot 0.
    request(2, 3, 0, 0, 0, 0, 3);
    check("count_after_first", int'(slot_count), 1);
    request(2, 3, 0, 1, 0, 0, 3);
    request(2, 3, 0, 0, 1, 0, 3);
    check("count_after_cap", int'(slot_count), 2);
    pulse_clear();
    check("count_after_clear", int'(slot_count), 0);

    // Fill all slots with distinct dims, then evict the globally oldest.
    request(1, 1, 0, 0, 0, 0, 3);
    request(1, 2, 0, 1, 0, 0, 3);
    request(1, 3, 0, 2, 0, 0, 3);
    request(1, 4, 0, 3, 0, 0, 3);
    request(1, 5, 0, 4, 0, 0, 3);
    request(2, 1, 0, 5, 0, 0, 3);
    request(2, 2, 0, 6, 0, 0, 3);
    request(2, 3, 0, 7, 0, 0, 3);
    check("count_full", int'(slot_count), 8);
    request(3, 3, 0, 0, 1, 0, 3);
    check("count_after_evict", int'(slot_count), 8);
    pulse_clear();

    // Held request grants once; a one-cycle drop re-arms it.
    request(1, 1, 0, 0, 0, 5, 0);
    request(2, 2, 0, 1, 0, 0, 3);
    check("count_after_hold", int'(slot_count), 2);

    // Illegal dimensions, including a value whose low bits look legal.
    request(6, 2, 1, 0, 0, 0, 3);
    request(0, 3, 1, 0, 0, 0, 3);
    request(32'h0000_0102, 1, 1, 0, 0, 0, 3);
    request(3, 0, 1, 0, 0, 0, 3);
    check("count_after_errs", int'(slot_count), 2);
    request(5, 5, 0, 2, 0, 0, 3);
    check("count_after_5x5", int'(slot_count), 3);

    // clear_all in the 4th SCAN cycle, then rst_n mid-SCAN, then clear at DECIDE.
    abort_request(4, 4, 4, 0);
    request(4, 4, 0, 0, 0, 0, 3);
    check("count_after_clear_scan", int'(slot_count), 1);
    abort_request(3, 2, 3, 1);
    request(4, 4, 0, 0, 0, 0, 3);
    check("count_after_reset_scan", int'(slot_count), 1);
    abort_request(3, 1, 9, 0);

    repeat (3) @(negedge clk);
    check("pending_expectations", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
